// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Purpose:
//   Multi-cycle WIDTH-bit adder. It processes one 4-bit nibble per clock
//   through a single 4-bit ripple-carry adder slice. A registered carry links
//   consecutive nibbles, so the long combinational carry chain of a full-width
//   adder is replaced by N = WIDTH/4 clock cycles.
//   Result: {cout, sum} = a + b + cin  (unsigned, modulo 2^WIDTH).
//
// Parameters:
//   WIDTH        operand/result width. Must be a multiple of 4 and >= 8.
//
// Optional feature (compile-time macro):
//   NSA_OVERFLOW_EN  when defined, ovf reports two's-complement overflow of
//                    the completed addition. When undefined, ovf is tied to 0
//                    and no overflow flop exists.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request a new addition (sampled in IDLE only)
//   a, b         in   operands, latched on the accepting edge
//   cin          in   carry-in, latched on the accepting edge
//   busy         out  high while RUN or DONE
//   done         out  one-cycle pulse; sum/cout/ovf valid from this cycle
//   sum          out  result register, held until the next completion
//   cout         out  final carry-out
//   ovf          out  two's-complement overflow (0 unless NSA_OVERFLOW_EN)
//   dbg_state_o  out  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake:
//   A request is accepted on the first rising edge where start=1 and the FSM
//   is IDLE. start in any other state is ignored, not queued. Exactly one
//   done pulse follows each accepted request, N cycles after the accepting
//   edge, unless reset intervenes; in that case no done pulse is produced.
// -----------------------------------------------------------------------------
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state_o
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // 4-bit ripple-carry slice operating on the low nibble of the operand
  // shift registers and the carry register.
  logic [3:0]       nib_sum;
  logic             nib_cout;

  always_comb begin : nibble_adder
    logic c;
    c       = carry_q;
    nib_sum = 4'd0;
    for (int i = 0; i < 4; i++) begin
      nib_sum[i] = a_q[i] ^ b_q[i] ^ c;
      c          = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    nib_cout = c;
  end

`ifdef NSA_OVERFLOW_EN
  logic ovf_q, ovf_d;
`endif

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef NSA_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // Nibbles arrive LSB first, so each new nibble enters at the MSB end.
        // After N shifts, nibble 0 has reached bits [3:0].
        res_d   = {nib_sum, res_q[WIDTH-1:4]};
        carry_d = nib_cout;
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_NIB) begin
          sum_d   = {nib_sum, res_q[WIDTH-1:4]};
          cout_d  = nib_cout;
`ifdef NSA_OVERFLOW_EN
          // On the last nibble, a_q[3]/b_q[3] are the original operand MSBs,
          // so no extra flops are needed to hold them.
          ovf_d   = (a_q[3] == b_q[3]) && (nib_sum[3] != a_q[3]);
`endif
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef NSA_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Directed bench for nibble_serial_adder (WIDTH=16). Stimulus tasks push the
// hand-computed expected {ovf, cout, sum} into exp_q. A monitor pops and
// compares on every done pulse. Timing items (latency, busy width,
// reset behaviour) are checked inline by the driver tasks.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

  localparam int W  = 16;
  localparam int EW = W + 2;

`ifdef NSA_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic [1:0]    dbg_state;

  int errors     = 0;
  int checks     = 0;
  int done_seen  = 0;

  logic [EW-1:0] exp_q[$];

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .busy        (busy),
    .done        (done),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_exp(input logic o, input logic c,
                                           input logic [W-1:0] s);
    return {o & OVF_EN, c, s};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [EW-1:0] e;
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got sum=0x%0h with no expectation queued", sum);
      end else begin
        e = exp_q.pop_front();
        check("sum",  32'(sum),  32'(e[W-1:0]));
        check("cout", 32'(cout), 32'(e[W]));
        check("ovf",  32'(ovf),  32'(e[W+1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one addition from IDLE; checks latency, busy width and pulse width.
  task automatic add_txn(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                         input logic c_v, input logic [EW-1:0] exp_v);
    int lat;
    int busy_cnt;
    bit seen;
    @(posedge clk); #1;
    a = a_v; b = b_v; cin = c_v; start = 1'b1;
    exp_q.push_back(exp_v);
    @(posedge clk); #1;           // accepting edge E0
    start = 1'b0;
    a = ~a_v; b = ~b_v; cin = ~c_v; // operands must already be latched
    lat = 0; busy_cnt = 0; seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (busy) busy_cnt++;
      if (done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done within 20 cycles, required 4");
      return;
    end
    check("latency", 32'(lat), 32'd4);
    @(posedge clk); #1;           // EN+1
    check("done_pulse_width", 32'(done), 32'd0);
    check("busy_cycles", 32'(busy_cnt + int'(busy)), 32'd5);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    logic [W-1:0] held_a[13];
    logic [W-1:0] held_b[13];
    logic         held_c[13];

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_sum",  32'(sum),  32'd0);
    check("post_rst_cout", 32'(cout), 32'd0);
    check("post_rst_ovf",  32'(ovf),  32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("idle_no_done", 32'(done_seen), 32'd0);

    // Basic add and carry-ripple vectors
    add_txn(16'h00FF, 16'h0001, 1'b0, mk_exp(1'b0, 1'b0, 16'h0100));
    add_txn(16'hFFFF, 16'h0000, 1'b1, mk_exp(1'b0, 1'b1, 16'h0000));
    add_txn(16'h1234, 16'h4321, 1'b0, mk_exp(1'b0, 1'b0, 16'h5555));
    add_txn(16'h7FFF, 16'h0001, 1'b0, mk_exp(1'b1, 1'b0, 16'h8000));

    // start held high with operands changing every cycle: only indices 0, 6
    // and 12 land on IDLE cycles.
    for (int i = 0; i < 13; i++) begin
      held_a[i] = 16'hFFFF; held_b[i] = 16'hFFFF; held_c[i] = 1'b1;
    end
    held_a[0]  = 16'h1111; held_b[0]  = 16'h2222; held_c[0]  = 1'b0;
    held_a[6]  = 16'h8000; held_b[6]  = 16'h8000; held_c[6]  = 1'b1;
    held_a[12] = 16'h0F0F; held_b[12] = 16'h00F1; held_c[12] = 1'b0;
    exp_q.push_back(mk_exp(1'b0, 1'b0, 16'h3333));
    exp_q.push_back(mk_exp(1'b1, 1'b1, 16'h0001));
    exp_q.push_back(mk_exp(1'b0, 1'b0, 16'h1000));
    d0 = done_seen;
    @(posedge clk); #1;
    for (int i = 0; i < 13; i++) begin
      a = held_a[i]; b = held_b[i]; cin = held_c[i]; start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("held_start_results", 32'(done_seen - d0), 32'd3);
    check("held_start_idle", 32'(busy), 32'd0);

    // Mid-operation reset: abort 0xAAAA+0x5555 two cycles after accept.
    d0 = done_seen;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sum",  32'(sum),  32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_ovf",  32'(ovf),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("mid_rst_no_done", 32'(done_seen - d0), 32'd0);
    check("mid_rst_sum_held", 32'(sum), 32'd0);

    add_txn(16'h0001, 16'h0001, 1'b0, mk_exp(1'b0, 1'b0, 16'h0002));

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
